// File: rtl/regfile_access_ctrl.sv
// ============================================================================
//  Module      : regfile_access_ctrl
//  Description : Accepts one register command per handshake and sequences the
//                register-file strobes (read/write/writeu/inc/dec) for it.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_access_ctrl #(
    parameter int DATA_W = 16,
    parameter int ID_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ID_W-1:0]   cmd_rd,
    input  logic [ID_W-1:0]   cmd_rs,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [DATA_W-1:0] rf_din,
    output logic              rf_read,
    output logic              rf_write,
    output logic              rf_writeu,
    output logic              rf_inc,
    output logic              rf_dec,
    output logic [ID_W-1:0]   rf_id,
    input  logic [DATA_W-1:0] rf_dout
);

    localparam logic [2:0] c_OP_NOP   = 3'd0;
    localparam logic [2:0] c_OP_READ  = 3'd1;
    localparam logic [2:0] c_OP_WRITE = 3'd2;
    localparam logic [2:0] c_OP_LOADU = 3'd3;
    localparam logic [2:0] c_OP_INC   = 3'd4;
    localparam logic [2:0] c_OP_DEC   = 3'd5;
    localparam logic [2:0] c_OP_MOV   = 3'd6;
    localparam logic [2:0] c_OP_SWAP  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR_A = 3'd3,
        S_WR_B = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              r_state;
    logic [2:0]          r_op;
    logic [ID_W-1:0]     r_rd;
    logic [ID_W-1:0]     r_rs;
    logic [DATA_W-1:0]   r_ta;
    logic [DATA_W-1:0]   r_tb;
    logic                r_cmd_ready;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_data;
    logic [DATA_W-1:0]   r_rf_din;
    logic                r_rf_read;
    logic                r_rf_write;
    logic                r_rf_writeu;
    logic                r_rf_inc;
    logic                r_rf_dec;
    logic [ID_W-1:0]     r_rf_id;

    // Upper-byte write carries the new byte in the low byte of din.
    logic [DATA_W-1:0]   w_imm_hi;
    assign w_imm_hi = {{(DATA_W-8){1'b0}}, cmd_imm[DATA_W-1 -: 8]};

    // Outputs are registered for the state being entered, so each strobe
    // lines up with the cycle its state occupies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= c_OP_NOP;
            r_rd         <= '0;
            r_rs         <= '0;
            r_ta         <= '0;
            r_tb         <= '0;
            r_cmd_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_rf_din     <= '0;
            r_rf_read    <= 1'b0;
            r_rf_write   <= 1'b0;
            r_rf_writeu  <= 1'b0;
            r_rf_inc     <= 1'b0;
            r_rf_dec     <= 1'b0;
            r_rf_id      <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_rf_read    <= 1'b0;
            r_rf_write   <= 1'b0;
            r_rf_writeu  <= 1'b0;
            r_rf_inc     <= 1'b0;
            r_rf_dec     <= 1'b0;
            r_rf_id      <= '0;
            r_rf_din     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= cmd_op;
                        r_rd        <= cmd_rd;
                        r_rs        <= cmd_rs;
                        case (cmd_op)
                            c_OP_READ, c_OP_MOV, c_OP_SWAP: begin
                                r_state   <= S_RD_A;
                                r_rf_read <= 1'b1;
                                r_rf_id   <= cmd_rs;
                            end
                            c_OP_WRITE: begin
                                r_state    <= S_WR_A;
                                r_rf_write <= 1'b1;
                                r_rf_id    <= cmd_rd;
                                r_rf_din   <= cmd_imm;
                            end
                            c_OP_LOADU: begin
                                r_state     <= S_WR_A;
                                r_rf_writeu <= 1'b1;
                                r_rf_id     <= cmd_rd;
                                r_rf_din    <= w_imm_hi;
                            end
                            c_OP_INC: begin
                                r_state  <= S_WR_A;
                                r_rf_inc <= 1'b1;
                                r_rf_id  <= cmd_rd;
                            end
                            c_OP_DEC: begin
                                r_state  <= S_WR_A;
                                r_rf_dec <= 1'b1;
                                r_rf_id  <= cmd_rd;
                            end
                            default: begin
                                r_state      <= S_DONE;
                                r_resp_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                S_RD_A: begin
                    r_ta <= rf_dout;
                    case (r_op)
                        c_OP_MOV: begin
                            // tA is still being captured, so forward the read data.
                            r_state    <= S_WR_A;
                            r_rf_write <= 1'b1;
                            r_rf_id    <= r_rd;
                            r_rf_din   <= rf_dout;
                        end
                        c_OP_SWAP: begin
                            r_state   <= S_RD_B;
                            r_rf_read <= 1'b1;
                            r_rf_id   <= r_rd;
                        end
                        default: begin
                            r_resp_data  <= rf_dout;
                            r_state      <= S_DONE;
                            r_resp_valid <= 1'b1;
                        end
                    endcase
                end
                S_RD_B: begin
                    r_tb       <= rf_dout;
                    r_state    <= S_WR_A;
                    r_rf_write <= 1'b1;
                    r_rf_id    <= r_rd;
                    r_rf_din   <= r_ta;
                end
                S_WR_A: begin
                    if (r_op == c_OP_SWAP) begin
                        r_state    <= S_WR_B;
                        r_rf_write <= 1'b1;
                        r_rf_id    <= r_rs;
                        r_rf_din   <= r_tb;
                    end else begin
                        r_state      <= S_DONE;
                        r_resp_valid <= 1'b1;
                    end
                end
                S_WR_B: begin
                    r_state      <= S_DONE;
                    r_resp_valid <= 1'b1;
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign rf_din     = r_rf_din;
    assign rf_read    = r_rf_read;
    assign rf_write   = r_rf_write;
    assign rf_writeu  = r_rf_writeu;
    assign rf_inc     = r_rf_inc;
    assign rf_dec     = r_rf_dec;
    assign rf_id      = r_rf_id;

endmodule

`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
// ============================================================================
//  Module      : tb_regfile_access_ctrl
//  Description : Scoreboard bench for regfile_access_ctrl with a register-file
//                model; strobe and response expectations are queued at issue.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_access_ctrl;

    localparam int DW = 16;
    localparam int IW = 5;

    localparam logic [4:0] K_RD = 5'b10000;
    localparam logic [4:0] K_WR = 5'b01000;
    localparam logic [4:0] K_WU = 5'b00100;
    localparam logic [4:0] K_IN = 5'b00010;
    localparam logic [4:0] K_DE = 5'b00001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [IW-1:0] cmd_rd = '0;
    logic [IW-1:0] cmd_rs = '0;
    logic [DW-1:0] cmd_imm = '0;
    logic          resp_valid;
    logic [DW-1:0] resp_data;
    logic [DW-1:0] rf_din;
    logic          rf_read, rf_write, rf_writeu, rf_inc, rf_dec;
    logic [IW-1:0] rf_id;
    logic [DW-1:0] rf_dout;

    regfile_access_ctrl #(.DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .rf_din(rf_din), .rf_read(rf_read), .rf_write(rf_write),
        .rf_writeu(rf_writeu), .rf_inc(rf_inc), .rf_dec(rf_dec),
        .rf_id(rf_id), .rf_dout(rf_dout)
    );

    always #5 clk = ~clk;

    // Register-file model driven by the DUT strobes
    logic [DW-1:0] mem [32] = '{default: '0};
    assign rf_dout = mem[rf_id];
    always @(posedge clk) begin
        if (rf_write)  mem[rf_id] <= rf_din;
        if (rf_writeu) mem[rf_id][15:8] <= rf_din[7:0];
        if (rf_inc)    mem[rf_id] <= mem[rf_id] + 16'd1;
        if (rf_dec)    mem[rf_id] <= mem[rf_id] - 16'd1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [4:0] kind; logic [4:0] id; logic [15:0] din; bit cd; } stb_t;
    typedef struct { logic [15:0] data; int cyc; } rsp_t;
    stb_t sq[$];
    rsp_t rq[$];

    // Reference state, updated from command semantics only
    logic [DW-1:0] s [32] = '{default: '0};
    logic [DW-1:0] last = '0;
    int busy_until = 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void push_s(input logic [4:0] k, input logic [4:0] id,
                                   input logic [15:0] din, input bit cd);
        stb_t t;
        t.kind = k; t.id = id; t.din = din; t.cd = cd;
        sq.push_back(t);
    endfunction

    always @(negedge clk) begin : mon
        logic [4:0] k;
        stb_t t;
        rsp_t r;
        if (!rst) begin
            k = {rf_read, rf_write, rf_writeu, rf_inc, rf_dec};
            check_eq("ready", {31'd0, cmd_ready}, {31'd0, (cyc > busy_until)});
            if (k != 5'd0) begin
                check_eq("onehot", $countones(k), 1);
                if (sq.size() == 0) begin
                    check_eq("unexp_strobe", {27'd0, k}, 0);
                end else begin
                    t = sq.pop_front();
                    check_eq("strobe_kind", {27'd0, k}, {27'd0, t.kind});
                    check_eq("strobe_id", {27'd0, rf_id}, {27'd0, t.id});
                    if (t.cd) check_eq("strobe_din", {16'd0, rf_din}, {16'd0, t.din});
                end
            end else begin
                check_eq("idle_id", {27'd0, rf_id}, 0);
                check_eq("idle_din", {16'd0, rf_din}, 0);
            end
            if (resp_valid) begin
                if (rq.size() == 0) begin
                    check_eq("unexp_resp", {31'd0, resp_valid}, 0);
                end else begin
                    r = rq.pop_front();
                    check_eq("resp_data", {16'd0, resp_data}, {16'd0, r.data});
                    check_eq("resp_cycle", cyc, r.cyc);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [15:0] imm, input bit hold);
        int n;
        int dur;
        int waitc;
        logic [15:0] a, b;
        rsp_t r;
        waitc = 0;
        @(negedge clk);
        while (!cmd_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!cmd_ready) begin
            check_eq("ready_timeout", {31'd0, cmd_ready}, 1);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm;
        n = cyc;
        dur = 2;
        case (op)
            3'd0: dur = 1;
            3'd1: begin push_s(K_RD, rs, 16'h0, 1'b0); last = s[rs]; end
            3'd2: begin push_s(K_WR, rd, imm, 1'b1); s[rd] = imm; end
            3'd3: begin push_s(K_WU, rd, {8'h00, imm[15:8]}, 1'b1); s[rd][15:8] = imm[15:8]; end
            3'd4: begin push_s(K_IN, rd, 16'h0, 1'b1); s[rd] = s[rd] + 16'd1; end
            3'd5: begin push_s(K_DE, rd, 16'h0, 1'b1); s[rd] = s[rd] - 16'd1; end
            3'd6: begin
                push_s(K_RD, rs, 16'h0, 1'b0);
                push_s(K_WR, rd, s[rs], 1'b1);
                s[rd] = s[rs];
                dur = 3;
            end
            default: begin
                a = s[rs]; b = s[rd];
                push_s(K_RD, rs, 16'h0, 1'b0);
                push_s(K_RD, rd, 16'h0, 1'b0);
                push_s(K_WR, rd, a, 1'b1);
                push_s(K_WR, rs, b, 1'b1);
                s[rd] = a; s[rs] = b;
                dur = 5;
            end
        endcase
        r.data = last;
        r.cyc  = n + dur;
        rq.push_back(r);
        @(posedge clk);
        #1;
        busy_until = n + dur;
        // While busy, the command bus carries junk that must be ignored
        cmd_valid = hold;
        cmd_op  = 3'($urandom_range(0, 7));
        cmd_rd  = 5'($urandom_range(0, 31));
        cmd_rs  = 5'($urandom_range(0, 31));
        cmd_imm = 16'($urandom);
    endtask

    logic [DW-1:0] saved [32];

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", {31'd0, cmd_ready}, 1);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 0);
        check_eq("rst_resp_data", {16'd0, resp_data}, 0);

        issue(3'd2, 5'd1, 5'd0, 16'h0F0F, 1'b0);
        issue(3'd1, 5'd0, 5'd1, 16'h0, 1'b0);

        issue(3'd2, 5'd0, 5'd0, 16'h1F0F, 1'b0);
        issue(3'd3, 5'd0, 5'd0, 16'hF300, 1'b0);
        issue(3'd1, 5'd0, 5'd0, 16'h0, 1'b0);

        issue(3'd2, 5'd0, 5'd0, 16'hFFFF, 1'b0);
        issue(3'd4, 5'd0, 5'd0, 16'h0, 1'b0);
        issue(3'd1, 5'd0, 5'd0, 16'h0, 1'b0);
        issue(3'd5, 5'd0, 5'd0, 16'h0, 1'b0);
        issue(3'd1, 5'd0, 5'd0, 16'h0, 1'b0);

        issue(3'd2, 5'd3, 5'd0, 16'hA5A5, 1'b0);
        issue(3'd6, 5'd5, 5'd3, 16'h0, 1'b0);
        issue(3'd1, 5'd0, 5'd5, 16'h0, 1'b0);
        issue(3'd6, 5'd3, 5'd3, 16'h0, 1'b0);
        issue(3'd1, 5'd0, 5'd3, 16'h0, 1'b0);

        issue(3'd2, 5'd2, 5'd0, 16'h1234, 1'b0);
        issue(3'd2, 5'd7, 5'd0, 16'hABCD, 1'b0);
        issue(3'd7, 5'd2, 5'd7, 16'h0, 1'b1);
        issue(3'd1, 5'd0, 5'd2, 16'h0, 1'b1);
        issue(3'd1, 5'd0, 5'd7, 16'h0, 1'b0);

        issue(3'd2, 5'd31, 5'd0, 16'h5A3C, 1'b0);
        issue(3'd7, 5'd31, 5'd31, 16'h0, 1'b0);
        issue(3'd1, 5'd0, 5'd31, 16'h0, 1'b0);
        issue(3'd0, 5'd0, 5'd0, 16'h0, 1'b0);

        // Abort a SWAP while it is in RD_B
        issue(3'd2, 5'd1, 5'd0, 16'h1111, 1'b0);
        issue(3'd2, 5'd2, 5'd0, 16'h2222, 1'b0);
        saved = s;
        issue(3'd7, 5'd2, 5'd1, 16'h0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_strobes", {27'd0, rf_read, rf_write, rf_writeu, rf_inc, rf_dec}, 0);
        check_eq("abort_ready", {31'd0, cmd_ready}, 1);
        check_eq("abort_resp_valid", {31'd0, resp_valid}, 0);
        check_eq("abort_resp_data", {16'd0, resp_data}, 0);
        sq.delete();
        rq.delete();
        s = saved;
        last = '0;
        busy_until = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_eq("abort_r1", {16'd0, mem[1]}, {16'd0, s[1]});
        check_eq("abort_r2", {16'd0, mem[2]}, {16'd0, s[2]});
        issue(3'd1, 5'd0, 5'd1, 16'h0, 1'b0);
        issue(3'd1, 5'd0, 5'd2, 16'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        issue(3'd0, 5'd0, 5'd0, 16'h0, 1'b0);

        repeat (10) @(negedge clk);
        check_eq("strobes_left", sq.size(), 0);
        check_eq("resps_left", rq.size(), 0);
        for (int i = 0; i < 32; i++) check_eq("final_mem", {16'd0, mem[i]}, {16'd0, s[i]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
Command-side initiator that drives the register file's strobe interface: din, read, write, writeu, inc, dec, id and dout. It accepts one high-level register command per valid/ready handshake. It then sequences the primitive strobes over one or more cycles and returns read data with a one-cycle response pulse. It sits between the decode/microcode stage and the register file, replacing ad-hoc strobe driving.

Parameters:
DATA_W, 16, register and data width
ID_W, 5, register index width (32 registers)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (IDLE only)
cmd_op  input  3  0 NOP, 1 READ, 2 WRITE, 3 LOADU, 4 INC, 5 DEC, 6 MOV, 7 SWAP
cmd_rd  input  ID_W  destination register
cmd_rs  input  ID_W  source register
cmd_imm  input  DATA_W  immediate for WRITE/LOADU
resp_valid  output  1  one-cycle completion pulse
resp_data  output  DATA_W  last captured read value
rf_din  output  DATA_W  register file din
rf_read  output  1  register file read strobe
rf_write  output  1  full-word write strobe
rf_writeu  output  1  upper-byte write strobe; data in rf_din[7:0]
rf_inc  output  1  increment strobe
rf_dec  output  1  decrement strobe
rf_id  output  ID_W  register file id
rf_dout  input  DATA_W  register file read data, valid in the same cycle rf_read is high

Behaviour:
- Reset is asynchronous and active-high. While rst=1 and at release: state IDLE, cmd_ready=1, resp_valid=0, resp_data=0, all rf strobes=0, rf_din=0, rf_id=0, and temp registers tA and tB = 0.
- Reset mid-operation aborts the command with no further strobes; register-file writes already completed are not undone.
- All rf_* outputs and resp_* are registered, so there are no combinational paths from cmd_* to any output.
- At most one of rf_read, rf_write, rf_writeu, rf_inc and rf_dec is high in any cycle.
- Each strobe is high for exactly one cycle. The register file acts on the rising edge that ends that cycle.
- Command handshake:
  - A command is accepted on the edge where cmd_valid=1 and cmd_ready=1.
  - cmd_rd, cmd_rs and cmd_imm are latched on that edge.
  - cmd_ready=0 from the next cycle until the cycle after DONE.
- States: IDLE, RD_A, RD_B, WR_A, WR_B, DONE. Per-op sequence after acceptance:
  - NOP: DONE. Duration: 1 cycle.
  - READ: RD_A (rf_read, rf_id=rs, tA<=rf_dout, resp_data<=rf_dout), then DONE. Duration: 2 cycles.
  - WRITE: WR_A (rf_write, rf_id=rd, rf_din=imm), then DONE. Duration: 2 cycles.
  - LOADU: WR_A (rf_writeu, rf_id=rd, rf_din={0, imm[15:8]}), then DONE. Duration: 2 cycles.
  - INC or DEC: WR_A (rf_inc or rf_dec, rf_id=rd, rf_din=0), then DONE. Duration: 2 cycles.
  - MOV: RD_A (read rs into tA), then WR_A (rf_write, rf_id=rd, rf_din=tA), then DONE. Duration: 3 cycles.
  - SWAP: RD_A (read rs into tA), RD_B (read rd into tB), WR_A (write rd<=tA), WR_B (write rs<=tB), then DONE. Duration: 5 cycles.
- DONE: resp_valid=1 for one cycle, strobes 0, rf_id=0, rf_din=0. The next state is IDLE.
- Response data:
  - resp_data is updated only by READ (RD_A) and holds its value otherwise.
  - MOV and SWAP do not change resp_data.
- In IDLE and DONE: rf_id=0 and rf_din=0.
- Back-to-back commands: the minimum spacing is the op duration plus 1 IDLE cycle.
- cmd_valid asserted while busy is ignored. Any change on cmd_* during a command has no effect.
- Boundary cases:
  - MOV with rd==rs writes the same value back.
  - SWAP with rd==rs runs the full 5 cycles and leaves the register unchanged.
  - INC and DEC wrap-around is owned by the register file; this block only issues the strobe.
  - Register index 31 is legal.

Test Plan:
- Reset: assert rst mid-SWAP (during RD_B) -> all strobes drop immediately, cmd_ready=1, resp_valid=0, and no write to r1 or r2 occurs.
- WRITE r1 imm=16'h0F0F, then READ r1 -> rf_write pulses with rf_id=1 and rf_din=16'h0F0F. On READ, resp_data=16'h0F0F, with resp_valid exactly 2 cycles after acceptance.
- WRITE r0 16'h1F0F, then LOADU r0 imm=16'hF300, then READ r0:
  - rf_writeu pulses with rf_din=16'h00F3.
  - resp_data equals the register file's upper-byte-write result, 16'hF30F.
- INC r0 then DEC r0 starting from 16'hFFFF:
  - Each op produces one rf_inc or rf_dec pulse.
  - READ returns 16'h0000 after INC and 16'hFFFF after DEC.
- MOV r5<=r3 with r3=16'hA5A5 -> rf_read (id 3), then rf_write (id 5, din 16'hA5A5), then resp_valid. READ r5 returns 16'hA5A5.
- SWAP r2,r7 with r2=16'h1234 and r7=16'hABCD:
  - Strobe order is read id 7, read id 2, write id 2=16'hABCD, write id 7=16'h1234.
  - Duration is 5 cycles.
  - cmd_valid held high throughout is accepted only after DONE, and one-hot strobe exclusion holds in every cycle.
